// File: rtl/gigatron_debug_ctrl.sv
// Gigatron debug controller: run/halt/step/run-N control,
// PC breakpoints and a show-ahead trace ring of retired cycles.
module gigatron_debug_ctrl #(
  parameter int NUM_BP      = 2,
  parameter int TRACE_DEPTH = 16,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_cmd_valid,
  input  logic [1:0]             i_cmd,
  input  logic [CNT_WIDTH-1:0]   i_cmd_count,
  output logic                   o_cmd_ready,
  output logic                   o_cmd_err,
  input  logic [NUM_BP-1:0]      i_bp_en,
  input  logic [16*NUM_BP-1:0]   i_bp_addr,
  input  logic [15:0]            i_pc,
  input  logic [7:0]             i_out,
  output logic                   o_ready,
  output logic [1:0]             o_state,
  output logic [1:0]             o_halt_cause,
  output logic [NUM_BP-1:0]      o_bp_hit,
  input  logic                   i_trace_rd,
  input  logic                   i_trace_clr,
  output logic                   o_trace_valid,
  output logic [15:0]            o_trace_pc,
  output logic [7:0]             o_trace_out,
  output logic                   o_trace_overflow
);

  localparam int PW = $clog2(TRACE_DEPTH);

  localparam logic [1:0] S_HALT  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_STEP  = 2'd2;
  localparam logic [1:0] S_COUNT = 2'd3;

  localparam logic [1:0] C_HALT  = 2'd0;
  localparam logic [1:0] C_RUN   = 2'd1;
  localparam logic [1:0] C_STEP  = 2'd2;
  localparam logic [1:0] C_RUN_N = 2'd3;

  logic [1:0]           state_q, state_d;
  logic                 first_q, first_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [1:0]           cause_q, cause_d;
  logic [NUM_BP-1:0]    hit_q, hit_d;
  logic                 err_q, err_d;
  logic [NUM_BP-1:0]    bp_vec;
  logic                 bp_stop;

  logic [23:0]          mem_q [TRACE_DEPTH];
  logic [PW-1:0]        wr_q, wr_d;
  logic [PW-1:0]        rd_q, rd_d;
  logic [PW:0]          occ_q, occ_d;
  logic                 ovf_q, ovf_d;
  logic                 push, pop, full;

  // Per-entry breakpoint compare against the presented PC
  always_comb begin
    bp_vec = '0;
    for (int k = 0; k < NUM_BP; k++) begin
      bp_vec[k] = i_bp_en[k] &&
                  (i_pc == i_bp_addr[16*k +: 16]);
    end
  end

  assign bp_stop = (|bp_vec) && !first_q;

  // State and control registers
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q <= S_HALT;
      first_q <= 1'b0;
      cnt_q   <= '0;
      cause_q <= 2'd0;
      hit_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      first_q <= first_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
      hit_q   <= hit_d;
      err_q   <= err_d;
    end
  end

  // Next state: commands first, then breakpoint, then completion
  always_comb begin
    state_d = state_q;
    first_d = first_q;
    cnt_d   = cnt_q;
    cause_d = cause_q;
    hit_d   = hit_q;
    err_d   = 1'b0;
    if (state_q == S_HALT) begin
      if (i_cmd_valid) begin
        case (i_cmd)
          C_RUN: begin
            state_d = S_RUN;
            first_d = 1'b1;
            hit_d   = '0;
          end
          C_STEP: begin
            state_d = S_STEP;
            first_d = 1'b1;
            hit_d   = '0;
          end
          C_RUN_N: begin
            if (i_cmd_count != '0) begin
              state_d = S_COUNT;
              cnt_d   = i_cmd_count;
              first_d = 1'b1;
              hit_d   = '0;
            end else begin
              cause_d = 2'd2;
            end
          end
          default: ;
        endcase
      end
    end else begin
      if (o_ready) first_d = 1'b0;
      if (o_ready && state_q == S_COUNT)
        cnt_d = cnt_q - CNT_WIDTH'(1);
      if (i_cmd_valid && i_cmd != C_HALT)
        err_d = 1'b1;
      if (i_cmd_valid && i_cmd == C_HALT) begin
        state_d = S_HALT;
        cause_d = 2'd0;
      end else if (bp_stop) begin
        state_d = S_HALT;
        cause_d = 2'd1;
        hit_d   = bp_vec;
      end else if (o_ready && state_q == S_STEP) begin
        state_d = S_HALT;
        cause_d = 2'd3;
      end else if (o_ready && state_q == S_COUNT &&
                   cnt_q == CNT_WIDTH'(1)) begin
        state_d = S_HALT;
        cause_d = 2'd2;
      end
    end
  end

  // CPU handshake and status outputs
  always_comb begin
    o_ready      = !i_reset && (state_q != S_HALT) && !bp_stop;
    o_state      = state_q;
    o_halt_cause = cause_q;
    o_bp_hit     = hit_q;
    o_cmd_err    = err_q;
    o_cmd_ready  = !i_reset;
  end

  assign push = o_ready;
  assign pop  = i_trace_rd && (occ_q != '0);
  assign full = (occ_q == (PW+1)'(TRACE_DEPTH));

  // Ring pointer update; a full push drops the oldest entry
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    occ_d = occ_q;
    ovf_d = ovf_q;
    if (i_trace_clr) begin
      wr_d  = '0;
      rd_d  = '0;
      occ_d = '0;
      ovf_d = 1'b0;
    end else begin
      if (push) wr_d = wr_q + PW'(1);
      if (pop) rd_d = rd_q + PW'(1);
      if (push && !pop) begin
        if (full) begin
          rd_d  = rd_q + PW'(1);
          ovf_d = 1'b1;
        end else begin
          occ_d = occ_q + (PW+1)'(1);
        end
      end else if (pop && !push) begin
        occ_d = occ_q - (PW+1)'(1);
      end
    end
  end

  // Ring pointer registers
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      occ_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      occ_q <= occ_d;
      ovf_q <= ovf_d;
    end
  end

  // Trace storage, written on each retired cycle
  always_ff @(posedge i_clock) begin
    if (push && !i_trace_clr)
      mem_q[wr_q] <= {i_pc, i_out};
  end

  assign o_trace_valid    = (occ_q != '0);
  assign o_trace_pc       = mem_q[rd_q][23:8];
  assign o_trace_out      = mem_q[rd_q][7:0];
  assign o_trace_overflow = ovf_q;

endmodule

// File: tb/tb_gigatron_debug_ctrl.sv
// Self-checking bench for gigatron_debug_ctrl: directed
// scenarios plus random traffic against a behavioural model.
module tb_gigatron_debug_ctrl;

  localparam int NBP = 2;
  localparam int TD  = 16;
  localparam int CW  = 16;

  localparam logic [1:0] C_HALT  = 2'd0;
  localparam logic [1:0] C_RUN   = 2'd1;
  localparam logic [1:0] C_STEP  = 2'd2;
  localparam logic [1:0] C_RUN_N = 2'd3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            i_cmd_valid = 1'b0;
  logic [1:0]      i_cmd = 2'd0;
  logic [CW-1:0]   i_cmd_count = '0;
  logic            o_cmd_ready;
  logic            o_cmd_err;
  logic [NBP-1:0]  i_bp_en = '0;
  logic [16*NBP-1:0] i_bp_addr = '0;
  logic [15:0]     i_pc = 16'h0000;
  logic [7:0]      i_out = 8'h00;
  logic            o_ready;
  logic [1:0]      o_state;
  logic [1:0]      o_halt_cause;
  logic [NBP-1:0]  o_bp_hit;
  logic            i_trace_rd = 1'b0;
  logic            i_trace_clr = 1'b0;
  logic            o_trace_valid;
  logic [15:0]     o_trace_pc;
  logic [7:0]      o_trace_out;
  logic            o_trace_overflow;

  always #5 clk = ~clk;

  gigatron_debug_ctrl #(
    .NUM_BP(NBP), .TRACE_DEPTH(TD), .CNT_WIDTH(CW)
  ) dut (
    .i_clock(clk),
    .i_reset(rst),
    .i_cmd_valid(i_cmd_valid),
    .i_cmd(i_cmd),
    .i_cmd_count(i_cmd_count),
    .o_cmd_ready(o_cmd_ready),
    .o_cmd_err(o_cmd_err),
    .i_bp_en(i_bp_en),
    .i_bp_addr(i_bp_addr),
    .i_pc(i_pc),
    .i_out(i_out),
    .o_ready(o_ready),
    .o_state(o_state),
    .o_halt_cause(o_halt_cause),
    .o_bp_hit(o_bp_hit),
    .i_trace_rd(i_trace_rd),
    .i_trace_clr(i_trace_clr),
    .o_trace_valid(o_trace_valid),
    .o_trace_pc(o_trace_pc),
    .o_trace_out(o_trace_out),
    .o_trace_overflow(o_trace_overflow)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input int act,
                     input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h",
               nm, act, exp);
    end
  endtask

  // Behavioural model: mode, pending count, trace as a queue
  int           m_state;
  int           m_cnt;
  int           m_cause;
  bit           m_first;
  bit           m_err;
  bit           m_ovf;
  int           m_hit;
  logic [23:0]  m_q[$];
  bit           e_ready;
  int           e_hits;

  task automatic mreset();
    m_state = 0;
    m_cnt   = 0;
    m_cause = 0;
    m_first = 0;
    m_err   = 0;
    m_ovf   = 0;
    m_hit   = 0;
    m_q.delete();
  endtask

  task automatic mcompute();
    e_hits = 0;
    for (int k = 0; k < NBP; k++)
      if (i_bp_en[k] && i_pc == i_bp_addr[16*k +: 16])
        e_hits = e_hits | (1 << k);
    e_ready = !rst && m_state != 0 &&
              !(e_hits != 0 && !m_first);
  endtask

  task automatic menter(input int s);
    m_state = s;
    m_first = 1;
    m_hit   = 0;
  endtask

  task automatic mstep();
    bit bpstop;
    bit popq;
    bpstop = (e_hits != 0) && !m_first;
    m_err = i_cmd_valid && m_state != 0 && i_cmd != C_HALT;
    if (i_trace_clr) begin
      m_q.delete();
      m_ovf = 0;
    end else begin
      popq = i_trace_rd && m_q.size() > 0;
      if (popq) void'(m_q.pop_front());
      if (e_ready) begin
        if (m_q.size() == TD) begin
          void'(m_q.pop_front());
          m_ovf = 1;
        end
        m_q.push_back({i_pc, i_out});
      end
    end
    if (m_state == 0) begin
      if (i_cmd_valid) begin
        if (i_cmd == C_RUN) menter(1);
        else if (i_cmd == C_STEP) menter(2);
        else if (i_cmd == C_RUN_N) begin
          if (i_cmd_count > 0) begin
            menter(3);
            m_cnt = int'(i_cmd_count);
          end else m_cause = 2;
        end
      end
    end else if (i_cmd_valid && i_cmd == C_HALT) begin
      m_state = 0;
      m_cause = 0;
    end else if (bpstop) begin
      m_state = 0;
      m_cause = 1;
      m_hit   = e_hits;
    end else begin
      m_first = 0;
      if (m_state == 2) begin
        m_state = 0;
        m_cause = 3;
      end else if (m_state == 3) begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) begin
          m_state = 0;
          m_cause = 2;
        end
      end
    end
  endtask

  // Compare every cycle, then advance the model at the edge
  initial begin
    mreset();
    forever begin
      @(negedge clk);
      #1;
      if (rst) mreset();
      mcompute();
      chk("ready", int'(o_ready), int'(e_ready));
      chk("state", int'(o_state), m_state);
      chk("cause", int'(o_halt_cause), m_cause);
      chk("bp_hit", int'(o_bp_hit), m_hit);
      chk("cmd_err", int'(o_cmd_err), int'(m_err));
      chk("cmd_ready", int'(o_cmd_ready), int'(!rst));
      chk("tr_valid", int'(o_trace_valid),
          int'(m_q.size() > 0));
      chk("tr_ovf", int'(o_trace_overflow), int'(m_ovf));
      if (m_q.size() > 0) begin
        chk("tr_pc", int'(o_trace_pc), int'(m_q[0][23:8]));
        chk("tr_out", int'(o_trace_out), int'(m_q[0][7:0]));
      end
      @(posedge clk);
      if (rst) mreset();
      else mstep();
    end
  end

  bit          last_ret;
  int          n_ret;
  logic [15:0] bp0;
  logic [15:0] pc0;
  int          r;

  // One cycle: the CPU advances its PC when it retired
  task automatic cyc();
    #1 last_ret = o_ready;
    @(negedge clk);
    if (last_ret) begin
      i_pc  = i_pc + 16'd1;
      n_ret = n_ret + 1;
    end
    i_cmd_valid = 1'b0;
    i_trace_rd  = 1'b0;
    i_trace_clr = 1'b0;
    i_out       = 8'($urandom);
  endtask

  task automatic cmd(input logic [1:0] c,
                     input logic [15:0] n);
    cyc();
    i_cmd_valid = 1'b1;
    i_cmd       = c;
    i_cmd_count = n;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    n_ret = 0;
    cyc();
    cyc();
    rst = 1'b0;
    cyc();
    chk("rst_state", int'(o_state), 0);
    chk("rst_tvalid", int'(o_trace_valid), 0);
    chk("rst_cmd_ready", int'(o_cmd_ready), 1);

    i_pc = 16'h0000;
    cmd(C_STEP, 16'd0);
    cyc();
    chk("step_in_step", int'(o_state), 2);
    cyc();
    chk("step_state", int'(o_state), 0);
    chk("step_cause", int'(o_halt_cause), 3);
    chk("step_tvalid", int'(o_trace_valid), 1);
    chk("step_tpc", int'(o_trace_pc), 0);
    i_trace_clr = 1'b1;

    cyc();
    i_pc      = 16'h000C;
    i_bp_en   = 2'b01;
    i_bp_addr = {16'hFFFF, 16'h0010};
    cmd(C_RUN, 16'd0);
    n_ret = 0;
    repeat (8) cyc();
    chk("bp_cause", int'(o_halt_cause), 1);
    chk("bp_state", int'(o_state), 0);
    chk("bp_hit_lit", int'(o_bp_hit), 1);
    chk("bp_retires", n_ret, 4);
    chk("bp_tpc", int'(o_trace_pc), 16'h000C);
    cmd(C_RUN, 16'd0);
    cyc();
    cyc();
    chk("bp_resume", int'(o_state), 1);
    chk("bp_resume_hit", int'(o_bp_hit), 0);

    cmd(C_STEP, 16'd0);
    cyc();
    chk("err_pulse", int'(o_cmd_err), 1);
    chk("err_state", int'(o_state), 1);
    cyc();
    chk("err_clear", int'(o_cmd_err), 0);
    bp0 = i_pc + 16'd3;
    i_bp_addr[15:0] = bp0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (i_pc == bp0) break;
    end
    i_cmd_valid = 1'b1;
    i_cmd       = C_HALT;
    cyc();
    chk("halt_bp_cause", int'(o_halt_cause), 0);
    chk("halt_bp_state", int'(o_state), 0);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("pop_seq", int'(o_trace_pc), 12 + i);
      i_trace_rd = 1'b1;
    end
    cyc();
    i_trace_clr = 1'b1;
    i_bp_en = '0;

    cmd(C_RUN_N, 16'd5);
    n_ret = 0;
    repeat (10) cyc();
    chk("runn_retires", n_ret, 5);
    chk("runn_cause", int'(o_halt_cause), 2);
    chk("runn_state", int'(o_state), 0);
    cmd(C_STEP, 16'd0);
    repeat (3) cyc();
    chk("step2_cause", int'(o_halt_cause), 3);
    cmd(C_RUN_N, 16'd0);
    n_ret = 0;
    repeat (4) cyc();
    chk("runn0_retires", n_ret, 0);
    chk("runn0_cause", int'(o_halt_cause), 2);
    chk("runn0_state", int'(o_state), 0);

    cyc();
    i_trace_clr = 1'b1;
    pc0 = i_pc;
    cmd(C_RUN, 16'd0);
    n_ret = 0;
    repeat (20) cyc();
    i_cmd_valid = 1'b1;
    i_cmd       = C_HALT;
    cyc();
    cyc();
    chk("ovf_retires", n_ret, 20);
    chk("ovf_set", int'(o_trace_overflow), 1);
    for (int i = 0; i < 16; i++) begin
      cyc();
      chk("ovf_pop", int'(o_trace_pc),
          int'(16'(pc0 + 16'(4 + i))));
      i_trace_rd = 1'b1;
    end
    cyc();
    chk("ovf_empty", int'(o_trace_valid), 0);
    i_trace_clr = 1'b1;
    cyc();
    chk("clr_valid", int'(o_trace_valid), 0);
    chk("clr_ovf", int'(o_trace_overflow), 0);

    cmd(C_RUN_N, 16'd10);
    n_ret = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (n_ret == 7) break;
    end
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", int'(o_ready), 0);
    chk("mid_rst_state", int'(o_state), 0);
    chk("mid_rst_tvalid", int'(o_trace_valid), 0);
    chk("mid_rst_cause", int'(o_halt_cause), 0);
    cyc();
    rst = 1'b0;
    cmd(C_RUN_N, 16'd2);
    n_ret = 0;
    repeat (6) cyc();
    chk("post_rst_retires", n_ret, 2);
    chk("post_rst_cause", int'(o_halt_cause), 2);

    for (int n = 0; n < 900; n++) begin
      cyc();
      rst = 1'b0;
      r = int'($urandom_range(0, 99));
      i_trace_rd = ($urandom_range(0, 3) == 0);
      if (r < 10) begin
        i_cmd_valid = 1'b1;
        i_cmd       = 2'($urandom_range(0, 3));
        i_cmd_count = 16'($urandom_range(0, 6));
      end else if (r < 12) begin
        i_trace_clr = 1'b1;
      end else if (r == 12) begin
        i_pc = 16'($urandom);
      end else if (r < 18) begin
        i_bp_en = 2'($urandom);
        for (int k = 0; k < NBP; k++)
          i_bp_addr[16*k +: 16] =
            i_pc + 16'($urandom_range(0, 8));
      end else if (r == 18) begin
        rst = 1'b1;
      end
    end
    cyc();
    rst = 1'b0;
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
